// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory slave for the MEM stage. Accepts one load/store at a
//            time over valid/ready, services it after a fixed LATENCY and
//            returns a one-cycle response pulse. Holds a word-organised RAM
//            with byte-enable stores and a saturating accepted-request count.
// Options  : DMEM_MISALIGN_TRAP_EN - when defined, requests with addr[1:0]!=0
//            respond with rsp_err=1, rdata=0 and never write the RAM. When
//            undefined, the low address bits are ignored and rsp_err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] access_count
);

  localparam int         c_DEPTH       = 1 << ADDR_W;
  localparam logic [3:0] c_LAT_INIT    = 4'(LATENCY - 1);
  localparam logic       c_DIRECT_RESP = 1'(LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [3:0]          r_latCnt;
  logic                w_accept;
  logic                w_enterResp;

  // Captured request
  logic                r_write;
  logic [ADDR_W-1:0]   r_wordIdx;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;

  // Operand actually used at the RAM edge: live request when LATENCY=1
  // (accept and RAM access share an edge), captured request otherwise.
  logic                w_opWrite;
  logic [ADDR_W-1:0]   w_opIdx;
  logic [31:0]         w_opWdata;
  logic [3:0]          w_opBe;
  logic                w_opMisalign;
  logic                w_misalignIn;

  logic [31:0]         r_mem [c_DEPTH];
  logic [31:0]         r_rspRdata;
  logic [15:0]         r_accessCount;

  // Address bits outside the word index carry no meaning for this RAM.
  logic                w_unusedBits;
  assign w_unusedBits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
  logic                r_misalign;
  logic                r_rspErr;

  assign w_misalignIn = (req_addr[1:0] != 2'b00);
  assign w_opMisalign = (r_state == IDLE) ? w_misalignIn : r_misalign;
  assign rsp_err      = r_rspErr;

  // Capture the misalignment flag with the rest of the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_misalign <= w_misalignIn;
    end
  end

  // Error flag updates only on a response and holds in between
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspErr <= 1'b0;
    end else if (w_enterResp) begin
      r_rspErr <= w_opMisalign;
    end
  end
`else
  assign w_misalignIn = 1'b0;
  assign w_opMisalign = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  assign w_accept    = (r_state == IDLE) && req_valid;
  // rst_n gates the RAM edge so an edge seen during reset never writes.
  assign w_enterResp = rst_n && (w_nextState == RESP);

  assign w_opWrite = (r_state == IDLE) ? req_write                 : r_write;
  assign w_opIdx   = (r_state == IDLE) ? req_addr[ADDR_W+1:2]      : r_wordIdx;
  assign w_opWdata = (r_state == IDLE) ? req_wdata                 : r_wdata;
  assign w_opBe    = (r_state == IDLE) ? req_be                    : r_be;

  assign rsp_rdata    = r_rspRdata;
  assign access_count = r_accessCount;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_nextState = c_DIRECT_RESP ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_latCnt <= 4'd1) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        rsp_valid   = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Latency counter: loaded on accept, counts down while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latCnt <= 4'd0;
    end else if (w_accept) begin
      r_latCnt <= c_LAT_INIT;
    end else if (r_state == WAIT) begin
      r_latCnt <= r_latCnt - 4'd1;
    end
  end

  // Request capture so later input activity cannot disturb the access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write   <= 1'b0;
      r_wordIdx <= '0;
      r_wdata   <= 32'd0;
      r_be      <= 4'd0;
    end else if (w_accept) begin
      r_write   <= req_write;
      r_wordIdx <= req_addr[ADDR_W+1:2];
      r_wdata   <= req_wdata;
      r_be      <= req_be;
    end
  end

  // Saturating count of accepted requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_accessCount <= 16'd0;
    end else if (w_accept && (r_accessCount != 16'hFFFF)) begin
      r_accessCount <= r_accessCount + 16'd1;
    end
  end

  // RAM byte-lane write on the edge entering RESP; contents are never reset
  always_ff @(posedge clk) begin
    if (w_enterResp && w_opWrite && !w_opMisalign) begin
      for (int b = 0; b < 4; b++) begin
        if (w_opBe[b]) begin
          r_mem[w_opIdx][8*b +: 8] <= w_opWdata[8*b +: 8];
        end
      end
    end
  end

  // Read data sampled on the edge entering RESP and held until next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspRdata <= 32'd0;
    end else if (w_enterResp) begin
      r_rspRdata <= (w_opWrite || w_opMisalign) ? 32'd0 : r_mem[w_opIdx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder (LATENCY=2, ADDR_W=10):
//            directed vector table, multi-cycle corner sequences and a
//            randomized run against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] access_count;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .access_count (access_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain word array plus a saturating integer count
  logic [31:0] mdlMem [DEPTH];
  int          mdlCount = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] be, output logic [31:0] r, output logic e);
    int idx;
    logic mis;
    idx = int'((a / 4) % DEPTH);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (a % 4) != 0;
`endif
    r = 32'd0;
    e = mis;
    if (!mis) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdlMem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        r = mdlMem[idx];
      end
    end
    if (mdlCount < 65535) mdlCount++;
  endfunction

  // Issue one request from a negedge, scramble inputs while busy, check response
  task automatic doReq(input string tag, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] expR, input logic expE);
    int waitC;
    int lat;
    waitC = 0;
    lat = 0;
    while (!req_ready && waitC < 20) begin
      @(negedge clk);
      waitC++;
    end
    if (!req_ready) begin
      chk({tag, " readyTimeout"}, 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    @(posedge clk);
    #1;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    for (int c = 1; c <= LATENCY + 4; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        break;
      end
      chk({tag, " busyReady"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(LATENCY));
    chk({tag, " rdata"}, rsp_rdata, expR);
    chk({tag, " err"}, 32'(rsp_err), 32'(expE));
    chk({tag, " count"}, {16'd0, access_count}, 32'(mdlCount));
    @(negedge clk);
    chk({tag, " pulseEnd"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rdataHold"}, rsp_rdata, expR);
    chk({tag, " readyBack"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be);
    logic [31:0] r;
    logic e;
    model(w, a, wd, be, r, e);
    doReq(tag, w, a, wd, be, r, e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          acc[$];
    int          baseCount;
    logic        seen;

    for (int i = 0; i < DEPTH; i++) mdlMem[i] = 32'd0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0044, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0, 32'h0102_0304, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0040, 32'h55AA_55AA, 4'hF, 32'h0000_0000, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[11] = '{1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'hF, 32'h55AA_55AA, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_1042, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
`else
    vecs[11] = '{1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_1042, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 1'b0};
`endif

    // Reset for three cycles, then idle checks
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("inResetRspValid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstReady", 32'(req_ready), 32'd1);
    chk("rstRspValid", 32'(rsp_valid), 32'd0);
    chk("rstCount", {16'd0, access_count}, 32'd0);
    chk("rstRdata", rsp_rdata, 32'd0);
    chk("rstErr", 32'(rsp_err), 32'd0);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      model(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be, r, e);
      doReq($sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
            vecs[i].be, vecs[i].expRdata, vecs[i].expErr);
    end

    // req_valid held high: accepts must land exactly every LATENCY+1 cycles
    baseCount = mdlCount;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_be    = 4'hF;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) acc.push_back(c);
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2bAccepts", 32'(acc.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++)
      chk($sformatf("b2bGap%0d", i), 32'(acc[i] - acc[i-1]), 32'(LATENCY + 1));
    chk("b2bCount", {16'd0, access_count}, 32'(baseCount + 4));
    for (int i = 0; i < 4; i++) model(1'b0, 32'd0, 32'd0, 4'hF, r, e);

    // Reset during WAIT aborts a pending store
    run("clr40", 1'b1, 32'h40, 32'h0, 4'hF);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    seen = rsp_valid;
    chk("abortCount", {16'd0, access_count}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abortNoRsp", 32'(seen), 32'd0);
    chk("abortRdata", rsp_rdata, 32'd0);
    mdlCount = 0;
    run("ldAfterAbort", 1'b0, 32'h40, 32'h0, 4'h0);

    // Give every word of the random window a known value
    for (int i = 0; i < 16; i++)
      run($sformatf("init%0d", i), 1'b1, 32'(i * 4), $urandom, 4'hF);

    // Randomized requests over a 16-word window with wrapping upper bits
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_F03F;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run($sformatf("rnd%0d", i), 1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
